// File: rtl/jk_mod_counter.sv
// jk_mod_counter: modulo-N up/down counter whose state lives entirely in
// one JK flip-flop cell per bit. Next-state is computed in binary and then
// translated into per-bit J/K excitation that drives the cells.

// Single positive-edge JK cell with asynchronous active-high reset.
module jk_cell (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q
);

    // JK behaviour: hold, clear, set, toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

module jk_mod_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    // The last legal count is N-1, which always fits in WIDTH bits even when
    // N equals 2^WIDTH. The range check for loads uses one extra bit so that
    // N = 2^WIDTH is representable.
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] next;
    logic             din_ok;
    logic             load_err_d;
    logic             at_last;
    logic             at_zero;

    assign din_ok  = ({1'b0, din} < MOD_EXT);
    assign at_last = (count == LAST);
    assign at_zero = (count == '0);

    // Terminal count is purely combinational so downstream stages see it in
    // the same cycle as the count value that triggers it.
    assign tc = en & ((up & at_last) | (~up & at_zero));

    // Priority-ordered next-state selection: load, then count, then hold.
    // Out-of-range loads clamp to N-1 so the counter never leaves 0..N-1.
    always_comb begin
        next       = count;
        load_err_d = 1'b0;
        if (load) begin
            if (din_ok) begin
                next = din;
            end else begin
                next       = LAST;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                next = at_last ? '0 : count + WIDTH'(1);
            end else begin
                next = at_zero ? LAST : count - WIDTH'(1);
            end
        end
    end

    // JK excitation: set only bits going 0->1, clear only bits going 1->0,
    // so the toggle combination is never presented to a cell.
    assign j_vec = next & ~count;
    assign k_vec = ~next & count;

    // One JK cell per bit holds the count; there is no shadow register.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (j_vec[i]),
            .k   (k_vec[i]),
            .q   (count[i])
        );
    end

    // Registered status pulses, aligned with the cycle showing the
    // post-wrap or clamped value; a load suppresses any wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= en & ~load & tc;
            load_err <= load_err_d;
        end
    end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter: directed and randomized checks of jk_mod_counter
// against an arithmetic modulo-N reference model.
module tb_jk_mod_counter;

    localparam int W = 4;
    localparam int N = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] din;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;
    logic         load_err;
    logic [W-1:0] j_vec;
    logic [W-1:0] k_vec;

    int vectors     = 0;
    int miscompares = 0;

    int m_count = 0;
    bit m_wrap  = 1'b0;
    bit m_lerr  = 1'b0;

    jk_mod_counter #(.WIDTH(W), .MODULUS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .load     (load),
        .din      (din),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap),
        .load_err (load_err),
        .j_vec    (j_vec),
        .k_vec    (k_vec)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Reference next count from the counting rules using plain integer
    // modulo arithmetic.
    function automatic int model_next(bit e, bit u, bit l, int d, int c);
        if (l) return (d < N) ? d : N - 1;
        if (e) return u ? (c + 1) % N : (c + N - 1) % N;
        return c;
    endfunction

    function automatic bit model_tc(bit e, bit u, int c);
        return e && ((u && c == N - 1) || (!u && c == 0));
    endfunction

    // Inputs change on the falling edge, well away from the active edge.
    task automatic set_inputs(bit e, bit u, bit l, int d);
        @(negedge clk);
        en   = e;
        up   = u;
        load = l;
        din  = W'(d);
        #1;
    endtask

    // Advance DUT and model across one rising edge; sample 1 time unit later.
    task automatic clock_edge();
        bit e = en;
        bit u = up;
        bit l = load;
        int d = int'(din);
        @(posedge clk);
        m_wrap  = !l && model_tc(e, u, m_count);
        m_lerr  = l && (d >= N);
        m_count = model_next(e, u, l, d, m_count);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; din = '0;
        #2;
        vectors++;
        if (count !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_init: count=%0d wrap=%b load_err=%b, expected 0/0/0", count, wrap, load_err);
        end
        m_count = 0; m_wrap = 0; m_lerr = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        set_inputs(0, 1, 1, 7);
        clock_edge();
        vectors++;
        if (count !== 4'd7) begin
            miscompares++;
            $display("[TB] FAIL reset_preload: count=%0d expected 7", count);
        end

        set_inputs(0, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (count !== 4'd0 || wrap !== 1'b0 || load_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_async: count=%0d wrap=%b load_err=%b, expected 0/0/0", count, wrap, load_err);
        end
        m_count = 0; m_wrap = 0; m_lerr = 0;
        set_inputs(1, 1, 0, 0);
        rst = 1'b0;
        clock_edge();
        vectors++;
        if (count !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL reset_first_step: count=%0d expected 1", count);
        end

        set_inputs(0, 1, 1, 9);
        clock_edge();
        set_inputs(1, 1, 0, 0);
        clock_edge();
        vectors++;
        if (wrap !== 1'b1 || count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_wrap_setup: wrap=%b count=%0d, expected 1/0", wrap, count);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (wrap !== 1'b0 || count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_cancel_wrap: wrap=%b count=%0d, expected 0/0", wrap, count);
        end
        m_count = 0; m_wrap = 0; m_lerr = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_up_count();
        set_inputs(0, 1, 1, 0);
        clock_edge();
        for (int i = 0; i < 11; i++) begin
            set_inputs(1, 1, 0, 0);
            vectors++;
            if (tc !== (m_count == N - 1)) begin
                miscompares++;
                $display("[TB] FAIL up_tc: tc=%b at count=%0d", tc, count);
            end
            if (m_count == N - 1) begin
                vectors++;
                if (j_vec !== 4'b0000 || k_vec !== 4'b1001) begin
                    miscompares++;
                    $display("[TB] FAIL up_jk_9to0: j=%b k=%b, expected 0000/1001", j_vec, k_vec);
                end
            end
            clock_edge();
            vectors++;
            if (count !== W'((i + 1) % N) || wrap !== (i == N - 1)) begin
                miscompares++;
                $display("[TB] FAIL up_step: count=%0d wrap=%b, expected %0d/%b", count, wrap, (i + 1) % N, i == N - 1);
            end
        end
    endtask

    task automatic test_down_count();
        int exp_seq [4] = '{1, 0, 9, 8};
        set_inputs(0, 1, 1, 2);
        clock_edge();
        for (int i = 0; i < 4; i++) begin
            set_inputs(1, 0, 0, 0);
            vectors++;
            if (tc !== (m_count == 0)) begin
                miscompares++;
                $display("[TB] FAIL down_tc: tc=%b at count=%0d", tc, count);
            end
            clock_edge();
            vectors++;
            if (count !== W'(exp_seq[i]) || wrap !== (exp_seq[i] == 9)) begin
                miscompares++;
                $display("[TB] FAIL down_step: count=%0d wrap=%b, expected %0d/%b", count, wrap, exp_seq[i], exp_seq[i] == 9);
            end
        end
    endtask

    task automatic test_load();
        set_inputs(0, 1, 1, 9);
        clock_edge();
        set_inputs(1, 1, 1, 6);
        vectors++;
        if (tc !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL load_tc: tc=%b expected 1", tc);
        end
        clock_edge();
        vectors++;
        if (count !== 4'd6 || wrap !== 1'b0 || load_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_wins: count=%0d wrap=%b load_err=%b, expected 6/0/0", count, wrap, load_err);
        end
        set_inputs(0, 1, 1, 13);
        clock_edge();
        vectors++;
        if (count !== 4'd9 || load_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL load_clamp: count=%0d load_err=%b, expected 9/1", count, load_err);
        end
        set_inputs(0, 1, 0, 0);
        clock_edge();
        vectors++;
        if (count !== 4'd9 || load_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL load_err_pulse: count=%0d load_err=%b, expected 9/0", count, load_err);
        end
    endtask

    task automatic test_hold_flip();
        set_inputs(0, 1, 1, 4);
        clock_edge();
        for (int i = 0; i < 3; i++) begin
            set_inputs(0, i[0], 0, 0);
            vectors++;
            if (j_vec !== 4'b0000 || k_vec !== 4'b0000) begin
                miscompares++;
                $display("[TB] FAIL hold_jk: j=%b k=%b, expected 0000/0000", j_vec, k_vec);
            end
            clock_edge();
            vectors++;
            if (count !== 4'd4) begin
                miscompares++;
                $display("[TB] FAIL hold_count: count=%0d expected 4", count);
            end
        end
        set_inputs(1, 1, 0, 0);
        clock_edge();
        set_inputs(1, 0, 0, 0);
        clock_edge();
        vectors++;
        if (count !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL dir_flip: count=%0d expected 4", count);
        end
    endtask

    task automatic test_back_to_back();
        set_inputs(0, 1, 1, 12);
        clock_edge();
        set_inputs(0, 1, 1, 15);
        clock_edge();
        vectors++;
        if (count !== 4'd9 || load_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_err_load: count=%0d load_err=%b, expected 9/1", count, load_err);
        end
        set_inputs(1, 0, 1, 0);
        clock_edge();
        vectors++;
        if (count !== 4'd0 || load_err !== 1'b0 || wrap !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_good_load: count=%0d load_err=%b wrap=%b, expected 0/0/0", count, load_err, wrap);
        end
        set_inputs(1, 0, 0, 0);
        clock_edge();
        vectors++;
        if (count !== 4'd9 || wrap !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL b2b_down_wrap: count=%0d wrap=%b, expected 9/1", count, wrap);
        end
        clock_edge();
        vectors++;
        if (count !== 4'd8 || wrap !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_wrap_clear: count=%0d wrap=%b, expected 8/0", count, wrap);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit e = ($urandom_range(0, 3) != 0);
            bit u = $urandom_range(0, 1) != 0;
            bit l = ($urandom_range(0, 7) == 0);
            int d = $urandom_range(0, 15);
            int nx = model_next(e, u, l, d, m_count);
            set_inputs(e, u, l, d);
            vectors++;
            if ((j_vec & k_vec) !== 4'b0000 || j_vec !== W'(nx & ~m_count) || k_vec !== W'(~nx & m_count)
                || tc !== model_tc(e, u, m_count)) begin
                miscompares++;
                $display("[TB] FAIL rand_comb: j=%b k=%b tc=%b, expected %b/%b/%b", j_vec, k_vec, tc,
                         W'(nx & ~m_count), W'(~nx & m_count), model_tc(e, u, m_count));
            end
            clock_edge();
            vectors++;
            if (count !== W'(m_count) || wrap !== m_wrap || load_err !== m_lerr) begin
                miscompares++;
                $display("[TB] FAIL rand_state: count=%0d wrap=%b load_err=%b, expected %0d/%b/%b",
                         count, wrap, load_err, m_count, m_wrap, m_lerr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_count();
        test_load();
        test_hold_flip();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
